// File: rtl/uart_pkg.sv
// Shared types for the UART echo buffer slice.
// TX handshake state encoding and pointer sizing helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int PTR_W = $clog2(FIFO_DEPTH_DEF);

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers and flush.
// Head word is read combinationally.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  // next pointers; flush beats push and pop
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + (AW+1)'(1);
      if (pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  // pointer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_q[AW-1:0]];
  assign level = wr_q - rd_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered RX-to-TX echo with single-pulse TX launch.
// Tracks overflow and a saturating drop count.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rx_valid,
  input  logic [PAYLOAD_BITS-1:0]       rx_data,
  input  logic                          rx_break,
  input  logic                          tx_busy,
  output logic                          tx_en,
  output logic [PAYLOAD_BITS-1:0]       tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [CNT_WIDTH-1:0]          drop_count
);

  tx_state_e                state_q, state_d;
  logic [PAYLOAD_BITS-1:0]  tx_data_q, tx_data_d;
  logic                     overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]     drop_q, drop_d;
  logic [PAYLOAD_BITS-1:0]  head;
  logic                     pop, push, push_req, drop;

  sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (rx_break),
    .push   (push),
    .pop    (pop),
    .wdata  (rx_data),
    .rdata  (head),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // TX handshake: pop in IDLE, pulse in LAUNCH, wait for busy edge pair
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy && !rx_break) begin
          pop       = 1'b1;
          tx_data_d = head;
          state_d   = LAUNCH;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // admission, drop accounting; a drop outranks a same-cycle clear
  always_comb begin
    push_req   = rx_valid && !rx_break;
    push       = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (overflow_clr)  drop_d = CNT_WIDTH'(1);
      else if (&drop_q)  drop_d = drop_q;
      else               drop_d = drop_q + CNT_WIDTH'(1);
    end
  end

  // state and status registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_en      = (state_q == LAUNCH);
  assign tx_data    = tx_data_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer.
// Includes a small transmitter model and a CNT_WIDTH=2 instance.
module tb_uart_echo_buffer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_break = 1'b0;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [4:0] fifo_level;
  logic       fifo_full, fifo_empty, overflow;
  logic       overflow_clr = 1'b0;
  logic [7:0] drop_count;

  logic       s_rx_valid = 1'b0;
  logic [7:0] s_rx_data = '0;
  logic       s_busy = 1'b1;
  logic       s_tx_en;
  logic [7:0] s_tx_data;
  logic [1:0] s_level;
  logic       s_full, s_empty, s_ovf;
  logic       s_clr = 1'b0;
  logic [1:0] s_drop;

  int n_checks = 0;
  int n_fail   = 0;

  int         frame_len  = 8;
  int         bcnt       = 0;
  logic       busy_force = 1'b0;
  logic [7:0] txq [$];
  int         tx_cnt = 0;

  always #5 clk = ~clk;

  assign tx_busy = busy_force | (bcnt != 0);

  uart_echo_buffer u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_break     (rx_break),
    .tx_busy      (tx_busy),
    .tx_en        (tx_en),
    .tx_data      (tx_data),
    .fifo_level   (fifo_level),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  uart_echo_buffer #(
    .PAYLOAD_BITS (8),
    .FIFO_DEPTH   (2),
    .CNT_WIDTH    (2)
  ) u_sat (
    .clk          (clk),
    .resetn       (resetn),
    .rx_valid     (s_rx_valid),
    .rx_data      (s_rx_data),
    .rx_break     (1'b0),
    .tx_busy      (s_busy),
    .tx_en        (s_tx_en),
    .tx_data      (s_tx_data),
    .fifo_level   (s_level),
    .fifo_full    (s_full),
    .fifo_empty   (s_empty),
    .overflow     (s_ovf),
    .overflow_clr (s_clr),
    .drop_count   (s_drop)
  );

  // transmitter model: busy for frame_len cycles after each start pulse
  always @(posedge clk) begin
    if (tx_en) begin
      txq.push_back(tx_data);
      tx_cnt++;
      bcnt <= frame_len;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      if (fifo_empty && !tx_busy && u_dut.state_q == 2'd0) ok = 1'b1;
      else step();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  int c0;
  logic seen;

  initial begin
    repeat (3) step();
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_state", 32'(u_dut.state_q), 0);
    resetn = 1'b1;
    repeat (2) step();

    // single word latency
    c0 = tx_cnt;
    push_word(8'hA5);
    check("lat_n1_en", 32'(tx_en), 0);
    check("lat_n1_lvl", 32'(fifo_level), 1);
    step();
    check("lat_n2_en", 32'(tx_en), 1);
    check("lat_n2_data", 32'(tx_data), 32'hA5);
    check("lat_n2_lvl", 32'(fifo_level), 0);
    step();
    check("lat_n3_en", 32'(tx_en), 0);
    wait_idle("single_idle", 100);
    check("single_cnt", 32'(tx_cnt - c0), 1);
    check("single_word", 32'(txq[0]), 32'hA5);

    // burst overflow
    txq.delete();
    c0 = tx_cnt;
    busy_force = 1'b1;
    for (int i = 0; i < 19; i++) push_word(8'(i));
    check("burst_full", 32'(fifo_full), 1);
    check("burst_lvl", 32'(fifo_level), 16);
    check("burst_ovf", 32'(overflow), 1);
    check("burst_drop", 32'(drop_count), 3);
    busy_force = 1'b0;
    step();
    wait_idle("burst_idle", 1000);
    check("burst_cnt", 32'(tx_cnt - c0), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("burst_w%0d", i), 32'(txq[i]), 32'(i));
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_drop", 32'(drop_count), 0);

    // push and pop in the same cycle at full
    txq.delete();
    c0 = tx_cnt;
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'(8'h20 + i));
    check("pp_full", 32'(fifo_full), 1);
    busy_force = 1'b0;
    push_word(8'h55);
    check("pp_lvl", 32'(fifo_level), 16);
    check("pp_ovf", 32'(overflow), 0);
    check("pp_drop", 32'(drop_count), 0);
    check("pp_en", 32'(tx_en), 1);
    wait_idle("pp_idle", 1000);
    check("pp_cnt", 32'(tx_cnt - c0), 17);
    check("pp_first", 32'(txq[0]), 32'h20);
    check("pp_last", 32'(txq[16]), 32'h55);

    // break flush while a word is in flight
    txq.delete();
    c0 = tx_cnt;
    frame_len = 30;
    push_word(8'h60);
    step();
    step();
    for (int i = 1; i <= 5; i++) push_word(8'(8'h60 + i));
    check("brk_pre_lvl", 32'(fifo_level), 5);
    check("brk_busy", 32'(tx_busy), 1);
    rx_break = 1'b1;
    push_word(8'h77);
    rx_break = 1'b0;
    check("brk_lvl", 32'(fifo_level), 0);
    check("brk_empty", 32'(fifo_empty), 1);
    check("brk_drop", 32'(drop_count), 0);
    check("brk_ovf", 32'(overflow), 0);
    wait_idle("brk_idle", 100);
    repeat (10) step();
    check("brk_cnt", 32'(tx_cnt - c0), 1);
    check("brk_word", 32'(txq[0]), 32'h60);

    // drop counter saturation and clear on the narrow instance
    for (int i = 0; i < 8; i++) begin
      s_rx_valid = 1'b1;
      s_rx_data  = 8'(i);
      step();
      s_rx_valid = 1'b0;
    end
    check("sat_lvl", 32'(s_level), 2);
    check("sat_ovf", 32'(s_ovf), 1);
    check("sat_drop", 32'(s_drop), 3);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    check("sclr_ovf", 32'(s_ovf), 0);
    check("sclr_drop", 32'(s_drop), 0);
    s_clr = 1'b1;
    s_rx_valid = 1'b1;
    step();
    s_clr = 1'b0;
    s_rx_valid = 1'b0;
    check("swin_ovf", 32'(s_ovf), 1);
    check("swin_drop", 32'(s_drop), 1);

    // asynchronous reset in WAIT_DONE with words buffered
    frame_len = 50;
    push_word(8'h70);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (u_dut.state_q == 2'd3) seen = 1'b1;
      else step();
    end
    check("ar_wait_done", 32'(seen), 1);
    for (int i = 0; i < 4; i++) push_word(8'(8'h71 + i));
    check("ar_pre_lvl", 32'(fifo_level), 4);
    #3;
    resetn = 1'b0;
    #1;
    check("ar_tx_en", 32'(tx_en), 0);
    check("ar_empty", 32'(fifo_empty), 1);
    check("ar_lvl", 32'(fifo_level), 0);
    check("ar_state", 32'(u_dut.state_q), 0);
    step();
    resetn = 1'b1;
    repeat (60) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
